// File: rtl/fir_driver_if.sv
// Host-side bundle of fir_driver: coefficient bank access with commit,
// valid/ready sample input and valid/ready filtered output.
interface fir_driver_if #(
  parameter int DataWidth = 12,
  parameter int NTaps     = 9
);
  localparam int NCoeffs   = (NTaps + 1) / 2;
  localparam int AddrWidth = $clog2(NCoeffs);

  logic                 cfg_we;
  logic [AddrWidth-1:0] cfg_addr;
  logic [DataWidth-1:0] cfg_wdata;
  logic                 cfg_commit;
  logic                 cfg_busy;
  logic                 s_valid;
  logic                 s_ready;
  logic [DataWidth-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DataWidth-1:0] m_data;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cfg_commit, s_valid, s_data, m_ready,
    input  cfg_busy, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, s_valid, s_data, m_ready,
    output cfg_busy, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fir_driver.sv
// Sequencer for the bit-serial symmetric FIR: serial coefficient loading from a
// shadow bank, one-sample-at-a-time start/done handling and a held output stage.
module fir_driver #(
  parameter int DataWidth = 12,
  parameter int NTaps     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_driver_if.slave          host,
  output logic                 fir_start,
  output logic [DataWidth-1:0] fir_x,
  output logic                 fir_coeff_load,
  output logic                 fir_coeff,
  input  logic                 fir_done,
  input  logic [DataWidth-1:0] fir_y
);
  localparam int NCoeffs   = (NTaps + 1) / 2;
  localparam int AddrWidth = $clog2(NCoeffs);
  localparam int NBits     = NCoeffs * DataWidth;
  localparam int CntWidth  = $clog2(NBits);
  localparam logic [CntWidth-1:0]  LastBit   = CntWidth'(NBits - 1);
  localparam logic [AddrWidth:0]   AddrLimit = (AddrWidth + 1)'(NCoeffs);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [DataWidth-1:0] bank_r [NCoeffs];
  logic [NBits-1:0]     shift_r;
  logic [NBits-1:0]     snap_s;
  logic [CntWidth-1:0]  cnt_r;
  logic                 pending_r;
  logic                 commit_s;
  logic                 snap_go_s;
  logic                 accept_s;
  logic [DataWidth-1:0] x_r;
  logic                 m_valid_r;
  logic [DataWidth-1:0] m_data_r;

  // A commit arriving in IDLE wins over a sample offered in the same cycle.
  assign commit_s = pending_r | host.cfg_commit;

  // Pack the bank with the centre tap in the MSBs so shifting out the top bit gives the load order.
  always_comb begin
    snap_s = '0;
    for (int i = 0; i < NCoeffs; i++) begin
      snap_s[i*DataWidth +: DataWidth] = bank_r[i];
    end
  end

  // Next-state and transition strobes.
  always_comb begin
    state_s   = state_r;
    snap_go_s = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (commit_s) begin
          state_s   = ST_LOAD;
          snap_go_s = 1'b1;
        end else if (host.s_valid && !m_valid_r) begin
          state_s  = ST_RUN;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_r == LastBit) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_GAP:  state_s = ST_IDLE;
      ST_RUN: begin
        if (fir_done) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign host.s_ready   = ~rst & (state_r == ST_IDLE) & ~commit_s & ~m_valid_r;
  assign host.cfg_busy  = pending_r | (state_r == ST_LOAD) | (state_r == ST_GAP);
  assign host.m_valid   = m_valid_r;
  assign host.m_data    = m_data_r;
  assign fir_start      = ~rst & accept_s;
  assign fir_x          = fir_start ? host.s_data : x_r;
  assign fir_coeff_load = (state_r == ST_LOAD);
  assign fir_coeff      = fir_coeff_load & shift_r[NBits-1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shadow coefficient bank; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCoeffs; i++) begin
        bank_r[i] <= '0;
      end
    end else if (host.cfg_we && ({1'b0, host.cfg_addr} < AddrLimit)) begin
      bank_r[host.cfg_addr] <= host.cfg_wdata;
    end
  end

  // Commit request held until IDLE can start the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && commit_s) begin
      pending_r <= 1'b0;
    end else if (host.cfg_commit) begin
      pending_r <= 1'b1;
    end
  end

  // Serial load shifter and bit counter working on the snapshot only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else if (snap_go_s) begin
      shift_r <= snap_s;
      cnt_r   <= '0;
    end else if (state_r == ST_LOAD) begin
      shift_r <= {shift_r[NBits-2:0], 1'b0};
      cnt_r   <= cnt_r + CntWidth'(1);
    end
  end

  // Last accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r <= '0;
    end else if (fir_start) begin
      x_r <= host.s_data;
    end
  end

  // Output stage holds the result until the downstream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
    end else if ((state_r == ST_RUN) && fir_done) begin
      m_valid_r <= 1'b1;
      m_data_r  <= fir_y;
    end else if (m_valid_r && host.m_ready) begin
      m_valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_driver.sv
// Self-checking bench for fir_driver with a behavioural bit-serial FIR attached
// and a scoreboard of expected filter outputs.
module tb_fir_driver;
  localparam int DW = 12;
  localparam int NT = 9;
  localparam int NC = 5;
  localparam int NB = NC * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_driver_if #(.DataWidth(DW), .NTaps(NT)) h();

  logic          fir_start;
  logic [DW-1:0] fir_x;
  logic          fir_coeff_load;
  logic          fir_coeff;
  logic          fir_done;
  logic [DW-1:0] fir_y;

  fir_driver #(.DataWidth(DW), .NTaps(NT)) dut (
    .clk(clk), .rst(rst), .host(h),
    .fir_start(fir_start), .fir_x(fir_x),
    .fir_coeff_load(fir_coeff_load), .fir_coeff(fir_coeff),
    .fir_done(fir_done), .fir_y(fir_y)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc_n = 0;
  int            acc_cyc = 0;
  int            overlap_n = 0;
  logic [DW-1:0] hc [NC];
  logic [DW-1:0] fexp [NC];
  logic [DW-1:0] bhist [NT];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] last_m;
  bit            prev_mv = 1'b0;
  bit            lbits [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Symmetric FIR in SFix<1,DW-1> coefficients, result truncated to DW bits.
  function automatic logic [DW-1:0] fir_calc(input logic [DW-1:0] c [NC], input logic [DW-1:0] s [NT]);
    longint acc = 0;
    logic [63:0] tmp;
    for (int k = 0; k < NT; k++) begin
      acc += longint'($signed(c[(k < NC) ? k : NT-1-k])) * longint'($signed(s[k]));
    end
    tmp = acc >>> (DW - 1);
    return tmp[DW-1:0];
  endfunction

  // Behavioural FIR: serial coefficient shift-in, done 61 cycles after start.
  logic [NB-1:0] m_coef = '0;
  logic [DW-1:0] m_hist [NT];
  logic [DW-1:0] m_y = '0;
  bit            m_act = 1'b0;
  int            m_cnt = 0;
  assign fir_done = m_act && (m_cnt == 0);
  assign fir_y    = m_y;

  always @(posedge clk) begin : fir_model
    logic [DW-1:0] s [NT];
    logic [DW-1:0] c [NC];
    cyc_n <= cyc_n + 1;
    if (fir_coeff_load) m_coef <= {m_coef[NB-2:0], fir_coeff};
    if (fir_start) begin
      s[0] = fir_x;
      for (int i = 1; i < NT; i++) s[i] = m_hist[i-1];
      for (int k = 0; k < NC; k++) c[k] = m_coef[k*DW +: DW];
      m_y    <= fir_calc(c, s);
      m_hist <= s;
      m_act  <= 1'b1;
      m_cnt  <= 60;
    end else if (m_act) begin
      if (m_cnt == 0) m_act <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  // Output monitor: latency on each rising m_valid, scoreboard on each handshake.
  always @(negedge clk) begin
    #2;
    if (fir_start && fir_coeff_load) overlap_n++;
    if (h.m_valid && !prev_mv) chk("latency", cyc_n - acc_cyc, 62);
    if (h.m_valid && h.m_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        last_m = h.m_data;
        chk("m_data", h.m_data, sb.pop_front());
      end
    end
    prev_mv = h.m_valid;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [DW-1:0] d);
    logic [31:0] av;
    av = a;
    h.cfg_we = 1'b1; h.cfg_addr = av[2:0]; h.cfg_wdata = d;
    step();
    h.cfg_we = 1'b0;
    if (a < NC) hc[a] = d;
  endtask

  task automatic commit();
    h.cfg_commit = 1'b1;
    step();
    h.cfg_commit = 1'b0;
    fexp = hc;
  endtask

  task automatic send_sample(input logic [DW-1:0] x, output int waited);
    waited = 0;
    h.s_valid = 1'b1; h.s_data = x;
    #1;
    while (!h.s_ready && waited < 400) begin step(); waited++; end
    chk("s_ready_accept", h.s_ready, 1);
    chk("fir_start", fir_start, 1);
    chk("fir_x", fir_x, x);
    acc_cyc = cyc_n;
    for (int i = NT-1; i > 0; i--) bhist[i] = bhist[i-1];
    bhist[0] = x;
    sb.push_back(fir_calc(fexp, bhist));
    step();
    h.s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || h.m_valid) && t < 400) begin step(); t++; end
    chk("drain", sb.size(), 0);
  endtask

  task automatic run_load(input logic [DW-1:0] first_exp, input logic [DW-1:0] last_exp);
    int t = 0;
    bit sr_bad = 1'b0;
    logic [NB-1:0] w = '0;
    lbits.delete();
    while (!fir_coeff_load && t < 300) begin step(); t++; end
    while (fir_coeff_load && t < 300) begin
      lbits.push_back(fir_coeff);
      if (h.s_ready) sr_bad = 1'b1;
      step(); t++;
    end
    chk("load_len", lbits.size(), NB);
    foreach (lbits[i]) w = {w[NB-2:0], lbits[i]};
    chk("load_first12", w[NB-1 -: DW], first_exp);
    chk("load_last12", w[DW-1:0], last_exp);
    chk("load_word", w, {fexp[4], fexp[3], fexp[2], fexp[1], fexp[0]});
    chk("load_sready", sr_bad, 0);
    chk("gap_busy", h.cfg_busy, 1);
    chk("gap_load", fir_coeff_load, 0);
    chk("gap_sready", h.s_ready, 0);
    step();
    chk("idle_busy", h.cfg_busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    int t;
    bit early;
    bit bad;
    logic [DW-1:0] hold_d;
    logic [DW-1:0] seq [5];
    seq = '{12'h100, 12'h000, 12'h000, 12'h000, 12'h000};
    for (int i = 0; i < NC; i++) begin hc[i] = '0; fexp[i] = '0; end
    for (int i = 0; i < NT; i++) begin bhist[i] = '0; m_hist[i] = '0; end
    h.cfg_we = 1'b0; h.cfg_addr = '0; h.cfg_wdata = '0; h.cfg_commit = 1'b0;
    h.s_valid = 1'b0; h.s_data = '0; h.m_ready = 1'b1;
    #1 rst = 1'b1;
    step(); step();
    chk("reset_outs", {h.m_valid, h.s_ready, h.cfg_busy, fir_start, fir_coeff_load,
                       fir_coeff, h.m_data, fir_x}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_release_sready", h.s_ready, 1);

    // Coefficient load ordering; the address-5 write must be dropped.
    cfg_write(0, 12'h001); cfg_write(1, 12'h002); cfg_write(2, 12'h004);
    cfg_write(3, 12'h008); cfg_write(4, 12'h400); cfg_write(5, 12'hfff);
    commit();
    run_load(12'h400, 12'h001);

    // Commit during RUN is deferred until the result appears.
    for (int i = 0; i < 4; i++) cfg_write(i, 12'h000);
    send_sample(12'h100, wt);
    repeat (5) step();
    commit();
    t = 0; early = 1'b0;
    while (!h.m_valid && t < 200) begin
      if (fir_coeff_load) early = 1'b1;
      step(); t++;
    end
    chk("no_load_in_run", early, 0);
    chk("run_mvalid", h.m_valid, 1);
    run_load(fexp[4], fexp[0]);

    // Impulse through the centre tap only.
    foreach (seq[i]) begin
      send_sample(seq[i], wt);
      drain();
    end
    chk("fifth_out", last_m, 12'h080);

    // Backpressure hold and release.
    h.m_ready = 1'b0;
    send_sample(12'h155, wt);
    t = 0;
    while (!h.m_valid && t < 200) begin step(); t++; end
    chk("bp_mvalid", h.m_valid, 1);
    hold_d = h.m_data;
    h.s_valid = 1'b1; h.s_data = 12'h0aa;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (h.m_data !== hold_d || !h.m_valid || h.s_ready || fir_start) bad = 1'b1;
    end
    chk("bp_hold", bad, 0);
    h.m_ready = 1'b1;
    step();
    h.m_ready = 1'b0;
    chk("bp_release_mvalid", h.m_valid, 0);
    send_sample(12'h0aa, wt);
    chk("bp_accept_next", wt, 0);
    h.m_ready = 1'b1;
    drain();

    // Commit and sample in the same IDLE cycle.
    h.cfg_commit = 1'b1; h.s_valid = 1'b1; h.s_data = 12'h321;
    #1;
    chk("prio_sready", h.s_ready, 0);
    chk("prio_start", fir_start, 0);
    step();
    h.cfg_commit = 1'b0;
    fexp = hc;
    run_load(fexp[4], fexp[0]);
    send_sample(12'h321, wt);
    chk("prio_accept_after_gap", wt, 0);
    drain();

    // Reset in the middle of a load wipes bank and pending.
    commit();
    t = 0;
    while (!fir_coeff_load && t < 50) begin step(); t++; end
    repeat (19) step();
    chk("mid_load_active", fir_coeff_load, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_reset_outs", {h.m_valid, h.s_ready, h.cfg_busy, fir_start, fir_coeff_load,
                           fir_coeff, h.m_data, fir_x}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_reset_busy", h.cfg_busy, 0);
    for (int i = 0; i < NC; i++) hc[i] = '0;
    commit();
    run_load(12'h000, 12'h000);

    repeat (3) step();
    chk("sb_empty_end", sb.size(), 0);
    chk("start_load_overlap", overlap_n, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_driver.md
Name: fir_driver

Overview:
- Initiator/controller for the team's bit-serial symmetric FIR engine. Drives its `start`, `coeff_load_in` and `coeff_in` inputs and consumes its `done` and `y` outputs.
- Host side has three interfaces: a parallel coefficient register bank with a commit strobe, a valid/ready sample input, and a valid/ready filtered output.
- Sits between the host/SPI register logic and the FIR instance. Owns all sequencing, so the host never sees the FIR's serial load order or its timing.

Parameters:
- DataWidth, 12, sample and coefficient width (coefficients SFix<1,DataWidth-1>).
- NTaps, 9, FIR tap count; must be odd.
- NCoeffs, (NTaps+1)/2, localparam, number of stored coefficients.
- AddrWidth, $clog2(NCoeffs), localparam, coefficient address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  write cfg_wdata into shadow coefficient cfg_addr
- cfg_addr  in  AddrWidth  coefficient index 0..NCoeffs-1; 0 = outermost taps, NCoeffs-1 = centre tap
- cfg_wdata  in  DataWidth  coefficient value
- cfg_commit  in  1  request serial load of the shadow bank into the FIR
- cfg_busy  out  1  commit pending or load in progress
- s_valid  in  1  input sample valid
- s_ready  out  1  driver accepts sample this cycle
- s_data  in  DataWidth  signed input sample
- m_valid  out  1  filtered output valid
- m_ready  in  1  downstream accepts output
- m_data  out  DataWidth  signed filtered output
- fir_start  out  1  FIR start pulse
- fir_x  out  DataWidth  FIR sample input
- fir_coeff_load  out  1  FIR coeff_load_in
- fir_coeff  out  1  FIR coeff_in serial bit
- fir_done  in  1  FIR done pulse
- fir_y  in  DataWidth  FIR output

Behaviour:
- Reset (async, rst=1): shadow bank = 0, state IDLE, pending = 0. All outputs 0 except m_data = 0.
- Shadow bank: a cfg_we write takes effect at the clock edge and is accepted in any state. An address >= NCoeffs is ignored.
- cfg_commit sets `pending`; a repeated commit while pending is a no-op.
- cfg_busy = pending | (state in LOAD, GAP).
- State IDLE:
  - If pending: snapshot the bank into an NCoeffs*DataWidth shift register, clear pending, go to LOAD. Commit has priority over samples.
  - Else if s_valid and !m_valid: s_ready=1, fir_start=1 and fir_x=s_data in the same cycle, go to RUN.
  - s_ready = (state==IDLE) & !pending & !m_valid, combinational.
- State LOAD:
  - fir_coeff_load=1 for exactly NCoeffs*DataWidth consecutive cycles.
  - Bit order on fir_coeff: coefficient NCoeffs-1 MSB first, down to coefficient 0, ending with its LSB.
  - After the last bit, go to GAP.
  - Writes during LOAD change only the bank, not the snapshot in flight.
- State GAP: one cycle with fir_coeff_load=0, which lets the FIR return to idle. Then go to IDLE.
- State RUN:
  - fir_start=0; wait for fir_done.
  - On fir_done=1: register fir_y into m_data, set m_valid, go to IDLE.
  - A commit arriving in RUN stays pending until IDLE.
- Output holding: m_valid stays high and m_data stays stable until m_valid & m_ready; m_valid then clears on the next edge.
- fir_x holds the last accepted sample; it is a don't-care outside the fir_start cycle.
- fir_start and fir_coeff_load are never high in the same cycle.
- Latency with the default FIR attached: fir_done arrives 61 cycles after the fir_start cycle, and m_valid rises 62 cycles after the s_valid&s_ready cycle.
- Reset mid-LOAD or mid-RUN: return immediately to reset values. A partial FIR load is discarded; the host must commit again.

Test Plan:
- Reset, then write cfg_addr 0..4 with 0x001,0x002,0x004,0x008,0x400 and pulse cfg_commit. Required: fir_coeff_load high for exactly 60 cycles; the first 12 bits are 0x400 MSB-first and the last 12 bits are 0x001 MSB-first; one GAP cycle follows; cfg_busy falls together with the return to IDLE.
- Pulse cfg_commit during RUN. Required: no fir_coeff_load until after m_valid rises, then a 60-cycle load; s_ready stays 0 throughout the load.
- Full system test (real FIR, symCoeffs=1, centre coefficient 0x400 = 0.5, others 0). Feed samples 0x100,0,0,0,0. Required: fifth output m_data = 0x080; other outputs 0; each m_valid appears 62 cycles after acceptance.
- Backpressure: hold m_ready=0 after the first output. Required: m_data stays stable, s_ready=0, and fir_start is not reasserted. Then raise m_ready for one cycle: m_valid clears and the next sample is accepted in the following cycle.
- Issue cfg_commit and s_valid in the same cycle in IDLE. Required: the load starts first and the sample is accepted only after GAP.
- Assert rst at cycle 20 of LOAD. Required: all outputs 0 asynchronously, pending=0, and the bank reads back 0 via a subsequent commit bitstream of all zeros.
